// File: rtl/block_draw_ctrl_pkg.sv
// Shared types and constants for the stacker block draw controller.
package stacker_pkg;

  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  // Controller states: draw, hold, decide, undraw, move, lock a row, end of game.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLOT   = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_ERASE  = 3'd4,
    S_UPDATE = 3'd5,
    S_LOCK   = 3'd6,
    S_OVER   = 3'd7
  } state_e;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_draw_ctrl_if.sv
// Player controls in, VGA adapter pixel stream and game status out.
interface block_draw_ctrl_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) ();
  import stacker_pkg::*;

  logic                start;
  logic                stop;
  logic [COLOUR_W-1:0] colour_in;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                writeEn;
  logic                locked;
  logic                game_over;

  // Game logic / player side.
  modport master (
    output start, stop, colour_in,
    input  x, y, colour, writeEn, locked, game_over
  );

  // Controller side.
  modport slave (
    input  start, stop, colour_in,
    output x, y, colour, writeEn, locked, game_over
  );
endinterface

// File: rtl/block_draw_ctrl_pixel_scan.sv
// Raster scan over one block: px fastest, wraps to (0,0) after the last pixel.
module pixel_scan #(
  parameter int BLK_W = 4,
  parameter int BLK_H = 4,
  parameter int PX_W  = 2,
  parameter int PY_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clear,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic            last
);

  localparam logic [PX_W-1:0] PX_MAX = PX_W'(BLK_W - 1);
  localparam logic [PY_W-1:0] PY_MAX = PY_W'(BLK_H - 1);

  logic [PX_W-1:0] px_q;
  logic [PY_W-1:0] py_q;

  // Advance one pixel per enabled cycle; the last pixel wraps back to the origin.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      px_q <= '0;
      py_q <= '0;
    end else if (en) begin
      if (px_q == PX_MAX) begin
        px_q <= '0;
        py_q <= (py_q == PY_MAX) ? '0 : py_q + PY_W'(1);
      end else begin
        px_q <= px_q + PX_W'(1);
      end
    end
  end

  assign px   = px_q;
  assign py   = py_q;
  assign last = (px_q == PX_MAX) && (py_q == PY_MAX);

endmodule

// File: rtl/block_draw_ctrl.sv
// Plot / delay / erase / move sequencer for one bouncing block with row stacking.
module block_draw_ctrl
  import stacker_pkg::*;
#(
  parameter int BLK_W   = 4,
  parameter int BLK_H   = 4,
  parameter int SCR_W   = 160,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int Y_START = 116,
  parameter int DELAY   = 833333,
  parameter int DELAY_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  block_draw_ctrl_if.slave  bus
);

  localparam int PX_W = cnt_w(BLK_W);
  localparam int PY_W = cnt_w(BLK_H);
  localparam logic [X_W-1:0]     X_MAX     = X_W'(SCR_W - BLK_W);
  localparam logic [DELAY_W-1:0] DLY_LOAD  = DELAY_W'(DELAY - 1);
  localparam bit                 NO_TRAVEL = (SCR_W == BLK_W);

  state_e             state_q, state_d;
  logic [X_W-1:0]     x_org_q, x_org_d;
  logic [Y_W-1:0]     y_org_q, y_org_d;
  logic               dir_right_q, dir_right_d;
  logic               stop_req_q, stop_req_d;
  logic [DELAY_W-1:0] dly_q, dly_d;

  logic            scan_en;
  logic            scan_clear;
  logic            scan_last;
  logic [PX_W-1:0] px;
  logic [PY_W-1:0] py;

  // Same scanner serves both drawing and erasing; held at the origin otherwise.
  assign scan_en    = (state_q == S_PLOT) || (state_q == S_ERASE);
  assign scan_clear = !scan_en;

  pixel_scan #(
    .BLK_W (BLK_W),
    .BLK_H (BLK_H),
    .PX_W  (PX_W),
    .PY_W  (PY_W)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .en    (scan_en),
    .clear (scan_clear),
    .px    (px),
    .py    (py),
    .last  (scan_last)
  );

  // State, origin, direction, stop latch and delay counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_org_q     <= '0;
      y_org_q     <= Y_W'(Y_START);
      dir_right_q <= 1'b1;
      stop_req_q  <= 1'b0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_org_q     <= x_org_d;
      y_org_q     <= y_org_d;
      dir_right_q <= dir_right_d;
      stop_req_q  <= stop_req_d;
      dly_q       <= dly_d;
    end
  end

  // Next-state, datapath updates and pixel outputs.
  always_comb begin
    state_d       = state_q;
    x_org_d       = x_org_q;
    y_org_d       = y_org_q;
    dir_right_d   = dir_right_q;
    stop_req_d    = stop_req_q;
    dly_d         = dly_q;
    bus.x         = x_org_q + X_W'(px);
    bus.y         = y_org_q + Y_W'(py);
    bus.colour    = COLOUR_BLACK;
    bus.writeEn   = 1'b0;
    bus.locked    = 1'b0;
    bus.game_over = 1'b0;

    // Stop is latched so a short press anywhere in the cycle reaches the next CHECK.
    if (bus.stop && (state_q != S_LOCK) && (state_q != S_OVER)) begin
      stop_req_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_PLOT;
      end
      S_PLOT: begin
        bus.writeEn = 1'b1;
        bus.colour  = bus.colour_in;
        if (scan_last) begin
          state_d = S_WAIT;
          dly_d   = DLY_LOAD;
        end
      end
      S_WAIT: begin
        if (dly_q == '0) state_d = S_CHECK;
        else             dly_d   = dly_q - DELAY_W'(1);
      end
      S_CHECK: begin
        state_d = stop_req_q ? S_LOCK : S_ERASE;
      end
      S_ERASE: begin
        bus.writeEn = 1'b1;
        bus.colour  = COLOUR_BLACK;
        if (scan_last) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // Bounce: at either edge flip direction and step back inward.
        if (!NO_TRAVEL) begin
          if (dir_right_q) begin
            if (x_org_q >= X_MAX) begin
              dir_right_d = 1'b0;
              x_org_d     = x_org_q - X_W'(1);
            end else begin
              x_org_d     = x_org_q + X_W'(1);
            end
          end else begin
            if (x_org_q == '0) begin
              dir_right_d = 1'b1;
              x_org_d     = x_org_q + X_W'(1);
            end else begin
              x_org_d     = x_org_q - X_W'(1);
            end
          end
        end
        state_d = S_PLOT;
      end
      S_LOCK: begin
        bus.locked  = 1'b1;
        stop_req_d  = 1'b0;
        x_org_d     = '0;
        dir_right_d = 1'b1;
        if (y_org_q < Y_W'(BLK_H)) begin
          state_d = S_OVER;
        end else begin
          y_org_d = y_org_q - Y_W'(BLK_H);
          state_d = S_IDLE;
        end
      end
      S_OVER: begin
        bus.game_over = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_draw_ctrl.sv
// Directed bench: per-cycle vector tables plus hand-written lock/reset sequences.
module tb_block_draw_ctrl;
  import stacker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  block_draw_ctrl_if #(.X_W(8), .Y_W(7)) bus_a ();
  block_draw_ctrl_if #(.X_W(8), .Y_W(7)) bus_b ();

  block_draw_ctrl #(
    .BLK_W(2), .BLK_H(2), .SCR_W(6), .X_W(8), .Y_W(7),
    .Y_START(4), .DELAY(4), .DELAY_W(3)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  block_draw_ctrl #(
    .BLK_W(2), .BLK_H(2), .SCR_W(6), .X_W(8), .Y_W(7),
    .Y_START(4), .DELAY(1), .DELAY_W(1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  typedef struct {
    bit         start;
    bit         stop;
    logic [2:0] col_in;
    bit         we;
    bit         chk_xy;
    int         x;
    int         y;
    logic [2:0] colour;
    bit         locked;
    bit         over;
  } vec_t;

  typedef struct {
    bit         we;
    int         x;
    int         y;
    logic [2:0] colour;
    bit         locked;
    bit         over;
  } out_t;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  localparam logic [2:0] CI = 3'b101;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic drive(input int sel, input bit st, input bit sp, input logic [2:0] c);
    if (sel == 0) begin
      bus_a.start = st; bus_a.stop = sp; bus_a.colour_in = c;
    end else begin
      bus_b.start = st; bus_b.stop = sp; bus_b.colour_in = c;
    end
  endtask

  function automatic out_t sample(input int sel);
    out_t o;
    if (sel == 0) begin
      o.we = bus_a.writeEn; o.x = int'(bus_a.x); o.y = int'(bus_a.y);
      o.colour = bus_a.colour; o.locked = bus_a.locked; o.over = bus_a.game_over;
    end else begin
      o.we = bus_b.writeEn; o.x = int'(bus_b.x); o.y = int'(bus_b.y);
      o.colour = bus_b.colour; o.locked = bus_b.locked; o.over = bus_b.game_over;
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit st, bit sp, bit we, bit cxy, int x, int y,
                              logic [2:0] col, bit lk, bit ov);
    vec_t v;
    v.start = st; v.stop = sp; v.col_in = CI; v.we = we; v.chk_xy = cxy;
    v.x = x; v.y = y; v.colour = col; v.locked = lk; v.over = ov;
    return v;
  endfunction

  // Plot pixel, erase pixel, quiet cycle, lock cycle, game-over cycle.
  function automatic vec_t vp(bit sp, int x, int y); return mk(1, sp, 1, 1, x, y, CI, 0, 0); endfunction
  function automatic vec_t ve(int x, int y);         return mk(1, 0, 1, 1, x, y, 3'b000, 0, 0); endfunction
  function automatic vec_t vn(bit sp);               return mk(1, sp, 0, 0, 0, 0, 3'b000, 0, 0); endfunction
  function automatic vec_t vl(bit sp);               return mk(1, sp, 0, 0, 0, 0, 3'b000, 1, 0); endfunction
  function automatic vec_t vo(bit sp);               return mk(1, sp, 0, 0, 0, 0, 3'b000, 0, 1); endfunction

  task automatic run_vecs(input int sel, input string tag);
    out_t o;
    bit   ok;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(sel, vecs[i].start, vecs[i].stop, vecs[i].col_in);
      step();
      o  = sample(sel);
      ok = (o.we == vecs[i].we) && (o.colour == vecs[i].colour) &&
           (o.locked == vecs[i].locked) && (o.over == vecs[i].over) &&
           (!vecs[i].chk_xy || (o.x == vecs[i].x && o.y == vecs[i].y));
      check($sformatf("%s[%0d]", tag, i), ok,
            $sformatf("got we=%0d x=%0d y=%0d col=%0d lk=%0d ov=%0d, want we=%0d x=%0d y=%0d col=%0d lk=%0d ov=%0d",
                      o.we, o.x, o.y, o.colour, o.locked, o.over,
                      vecs[i].we, vecs[i].x, vecs[i].y, vecs[i].colour, vecs[i].locked, vecs[i].over));
      $display("%s[%0d] we=%0d x=%0d y=%0d col=%0d lk=%0d ov=%0d", tag, i,
               o.we, o.x, o.y, o.colour, o.locked, o.over);
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    drive(0, 0, 0, CI);
    step();
    rst_a = 1'b0;
  endtask

  // Wait up to 'budget' cycles for a lock pulse on dut_a.
  task automatic wait_lock_a(input int budget, output bit seen);
    out_t o;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      o = sample(0);
      if (o.locked) seen = 1'b1;
    end
  endtask

  initial begin
    out_t o;
    int   xs[$];
    int   exp_x[10];
    bit   prev_plot;
    int   lock_cyc, lock_cnt, erase_cnt, idle_we, bad;
    bit   seen, erase_seen, lock_seen;

    drive(0, 0, 0, CI);
    drive(1, 0, 0, CI);

    // Reset state.
    step(); step();
    o = sample(0);
    check("reset_outputs", !o.we && o.colour == 3'b000 && !o.locked && !o.over,
          $sformatf("got we=%0d col=%0d lk=%0d ov=%0d, want all 0", o.we, o.colour, o.locked, o.over));
    $display("reset we=%0d col=%0d lk=%0d ov=%0d", o.we, o.colour, o.locked, o.over);
    rst_a = 1'b0;

    // 1: plot, 4 wait cycles, check, erase, update, next plot one step right.
    vecs = {};
    vecs.push_back(vp(0, 0, 4)); vecs.push_back(vp(0, 1, 4));
    vecs.push_back(vp(0, 0, 5)); vecs.push_back(vp(0, 1, 5));
    for (int i = 0; i < 4; i++) vecs.push_back(vn(0));
    vecs.push_back(vn(0));
    vecs.push_back(ve(0, 4)); vecs.push_back(ve(1, 4));
    vecs.push_back(ve(0, 5)); vecs.push_back(ve(1, 5));
    vecs.push_back(vn(0));
    vecs.push_back(vp(0, 1, 4));
    run_vecs(0, "seq1");

    // 2: free run, origin at each plot start bounces 0..4..0.
    exp_x = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    reset_a();
    drive(0, 1, 0, CI);
    xs = {};
    prev_plot = 1'b0;
    for (int c = 0; c < 400 && xs.size() < 10; c++) begin
      step();
      o = sample(0);
      if (o.we && o.colour == CI && !prev_plot) xs.push_back(o.x);
      prev_plot = o.we && (o.colour == CI);
    end
    check("bounce_count", xs.size() == 10,
          $sformatf("got %0d plot starts, want 10", xs.size()));
    for (int i = 0; i < 10 && i < xs.size(); i++) begin
      check($sformatf("bounce_x[%0d]", i), xs[i] == exp_x[i],
            $sformatf("got x_org=%0d, want %0d", xs[i], exp_x[i]));
      $display("bounce[%0d] x_org=%0d", i, xs[i]);
    end

    // 3: one-cycle stop pulse on the 2nd plot pixel -> lock, no erase.
    reset_a();
    drive(0, 1, 0, CI);
    step();
    drive(0, 0, 1, CI);
    step();
    drive(0, 0, 0, CI);
    lock_cyc = -1; lock_cnt = 0; erase_cnt = 0; idle_we = 0;
    for (int c = 3; c <= 30; c++) begin
      step();
      o = sample(0);
      if (o.locked) begin
        lock_cnt++;
        if (lock_cyc < 0) lock_cyc = c;
      end
      if (o.we && o.colour == 3'b000) erase_cnt++;
      if (lock_cyc >= 0 && c > lock_cyc && o.we) idle_we++;
    end
    check("stop_lock_cycle", lock_cyc == 10, $sformatf("got lock at cycle %0d, want 10", lock_cyc));
    check("stop_lock_count", lock_cnt == 1, $sformatf("got %0d lock pulses, want 1", lock_cnt));
    check("stop_no_erase", erase_cnt == 0, $sformatf("got %0d erase writes, want 0", erase_cnt));
    check("stop_idle_quiet", idle_we == 0, $sformatf("got %0d writes in idle, want 0", idle_we));
    $display("stop: lock_cyc=%0d locks=%0d erases=%0d idle_we=%0d", lock_cyc, lock_cnt, erase_cnt, idle_we);
    drive(0, 1, 0, CI);
    step();
    o = sample(0);
    check("row2_first_pixel", o.we && o.x == 0 && o.y == 2 && o.colour == CI,
          $sformatf("got we=%0d x=%0d y=%0d col=%0d, want we=1 x=0 y=2 col=%0d", o.we, o.x, o.y, o.colour, CI));
    $display("row2 first pixel x=%0d y=%0d", o.x, o.y);

    // 4: lock rows at y=2 and y=0; the second enters game over.
    drive(0, 0, 1, CI);
    step();
    drive(0, 0, 0, CI);
    wait_lock_a(40, seen);
    check("row2_lock", seen, $sformatf("got locked=%0d within budget, want 1", seen));
    step();
    drive(0, 1, 0, CI);
    step();
    o = sample(0);
    check("row0_first_pixel", o.we && o.x == 0 && o.y == 0 && !o.over,
          $sformatf("got we=%0d x=%0d y=%0d ov=%0d, want we=1 x=0 y=0 ov=0", o.we, o.x, o.y, o.over));
    $display("row0 first pixel x=%0d y=%0d", o.x, o.y);
    drive(0, 0, 1, CI);
    step();
    drive(0, 0, 0, CI);
    wait_lock_a(40, seen);
    check("row0_lock", seen, $sformatf("got locked=%0d within budget, want 1", seen));
    step();
    o = sample(0);
    check("game_over_set", o.over && !o.we,
          $sformatf("got ov=%0d we=%0d, want ov=1 we=0", o.over, o.we));
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      drive(0, 1, c[0], CI);
      step();
      o = sample(0);
      if (!o.over || o.we || o.locked) bad++;
    end
    check("game_over_sticky", bad == 0, $sformatf("got %0d bad cycles, want 0", bad));
    $display("game over: bad cycles=%0d", bad);

    // 5: reset on the 2nd plot pixel, with a stop already latched.
    reset_a();
    drive(0, 1, 1, CI);
    step();
    drive(0, 1, 0, CI);
    step();
    o = sample(0);
    check("mid_plot_pixel", o.we && o.x == 1 && o.y == 4,
          $sformatf("got we=%0d x=%0d y=%0d, want we=1 x=1 y=4", o.we, o.x, o.y));
    rst_a = 1'b1;
    step();
    o = sample(0);
    check("mid_reset_we", !o.we, $sformatf("got we=%0d, want 0", o.we));
    rst_a = 1'b0;
    drive(0, 0, 0, CI);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      o = sample(0);
      if (o.we) bad++;
    end
    check("mid_reset_idle", bad == 0, $sformatf("got %0d writes while idle, want 0", bad));
    drive(0, 1, 0, CI);
    step();
    o = sample(0);
    check("mid_reset_origin", o.we && o.x == 0 && o.y == 4,
          $sformatf("got we=%0d x=%0d y=%0d, want we=1 x=0 y=4", o.we, o.x, o.y));
    drive(0, 0, 0, CI);
    erase_seen = 1'b0; lock_seen = 1'b0;
    for (int c = 0; c < 30 && !erase_seen; c++) begin
      step();
      o = sample(0);
      if (o.locked) lock_seen = 1'b1;
      if (o.we && o.colour == 3'b000) erase_seen = 1'b1;
    end
    check("stop_req_cleared", erase_seen && !lock_seen,
          $sformatf("got erase=%0d lock=%0d, want erase=1 lock=0", erase_seen, lock_seen));
    $display("after reset: erase=%0d lock=%0d", erase_seen, lock_seen);

    // 6: DELAY=1, stop held: every row locks at x_org=0 until game over.
    drive(1, 1, 1, CI);
    step();
    rst_b = 1'b0;
    vecs = {};
    for (int r = 0; r < 3; r++) begin
      vecs.push_back(vp(1, 0, 4 - 2 * r)); vecs.push_back(vp(1, 1, 4 - 2 * r));
      vecs.push_back(vp(1, 0, 5 - 2 * r)); vecs.push_back(vp(1, 1, 5 - 2 * r));
      vecs.push_back(vn(1));
      vecs.push_back(vn(1));
      vecs.push_back(vl(1));
      if (r < 2) vecs.push_back(vn(1));
      else       vecs.push_back(vo(1));
    end
    run_vecs(1, "seq6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
